// File: rtl/game_soc_pio_pkg.sv
// Shared constants for the keys PIO: register word addresses, edge-select
// encodings and a per-bit edge-detect helper.
package game_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    typedef enum int {
        EDGE_RISING  = 0,
        EDGE_FALLING = 1,
        EDGE_ANY     = 2
    } edge_sel_e;

    function automatic logic edge_bit(input logic cur, input logic prev, input int sel);
        logic r;
        case (sel)
            EDGE_RISING:  r = cur & ~prev;
            EDGE_FALLING: r = ~cur & prev;
            default:      r = cur ^ prev;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/game_soc_pio_debounce.sv
// Per-bit debouncer: a bit of stable_o follows sync_i only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive clocks.
module game_soc_pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sync_i,
    output logic [WIDTH-1:0] stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic          stable_q, stable_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // Any agreement between input and output restarts the count.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync_i[gi] != stable_q) begin
                    if (cnt_q == CNT_MAX) begin
                        stable_d = sync_i[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable_q <= 1'b1;
                    cnt_q    <= '0;
                end else begin
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign stable_o[gi] = stable_q;
        end
    endgenerate

endmodule

// File: rtl/game_soc_keys_pio.sv
// Avalon-MM key input PIO with edge capture and level IRQ.
// Define GAME_SOC_KEYS_DEBOUNCE_EN to insert per-bit debouncing after the synchronizer.
module game_soc_keys_pio
    import game_soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_SEL        = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;

    // Keys idle high, so every front-end stage resets to ones to avoid a
    // spurious edge when reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            stable_dly_q <= '1;
            irq_mask_q   <= '0;
            edge_cap_q   <= '0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable;
            irq_mask_q   <= irq_mask_d;
            edge_cap_q   <= edge_cap_d;
        end
    end

`ifdef GAME_SOC_KEYS_DEBOUNCE_EN
    game_soc_pio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .sync_i   (sync2_q),
        .stable_o (stable)
    );
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    logic [WIDTH-1:0] stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '1;
        end else begin
            stable_q <= sync2_q;
        end
    end

    assign stable = stable_q;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign edge_det[gi] = edge_bit(stable[gi], stable_dly_q[gi], EDGE_SEL);
        end
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    // A fresh edge is OR-ed in after the clear so it wins over a same-cycle W1C.
    always_comb begin
        irq_mask_d = irq_mask_q;
        clr_mask   = '0;
        if (wr_en && address == ADDR_IRQ_MASK) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE_CAP) begin
            clr_mask = writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~clr_mask) | edge_det;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = stable;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_game_soc_keys_pio.sv
// Directed bench for game_soc_keys_pio; expectations are queued as stimulus is
// driven and popped/compared against readdata or irq.
module tb_game_soc_keys_pio;

    localparam int D = 16;
`ifdef GAME_SOC_KEYS_DEBOUNCE_EN
    localparam int LAT     = D + 2;
    localparam int PRE_RST = 2 + 8;
`else
    localparam int LAT     = 3;
    localparam int PRE_RST = 2;
`endif
    localparam logic [2:0] SEL_IRQ = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [2:0]  sel;
        logic [31:0] exp;
    } item_t;
    item_t sb[$];

    game_soc_keys_pio #(
        .WIDTH           (4),
        .EDGE_SEL        (1),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #50 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.sel != SEL_IRQ) address = it.sel[1:0];
            #1;
            obs = (it.sel == SEL_IRQ) ? {31'b0, irq} : readdata;
            total++;
            assert (obs === it.exp) else begin
                bad++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", it.tag, obs, it.exp);
            end
            $display("check %-18s sel=%0d observed=0x%08h expected=0x%08h",
                     it.tag, it.sel, obs, it.exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset      = 1'b1;
        in_port    = 4'hF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        tick(2);
        reset = 1'b0;
        push("rst_data", 3'd0, 32'hF);
        push("rst_rsvd", 3'd1, 32'h0);
        push("rst_mask", 3'd2, 32'h0);
        push("rst_cap",  3'd3, 32'h0);
        push("rst_irq",  SEL_IRQ, 32'h0);
        drain();

        // Falling edge on bit 0: data latency, then capture one edge later.
        in_port = 4'hE;
        tick(LAT - 1);
        push("fall_data_early", 3'd0, 32'hF);
        drain();
        tick(1);
        push("fall_data", 3'd0, 32'hE);
        push("fall_cap_early", 3'd3, 32'h0);
        drain();
        tick(1);
        push("fall_cap", 3'd3, 32'h1);
        push("fall_irq_masked", SEL_IRQ, 32'h0);
        drain();

        // IRQ path.
        wr(2'd2, 32'h1);
        push("mask_rd", 3'd2, 32'h1);
        push("irq_on", SEL_IRQ, 32'h1);
        drain();
        wr(2'd3, 32'h1);
        push("w1c_cap", 3'd3, 32'h0);
        push("irq_off", SEL_IRQ, 32'h0);
        drain();

        // Clear and new edge on bit 2 in the same cycle.
        in_port = 4'hA;
        tick(LAT);
        wr(2'd3, 32'h4);
        push("edge_wins", 3'd3, 32'h4);
        push("edge_wins_irq", SEL_IRQ, 32'h0);
        drain();
        wr(2'd3, 32'h0);
        push("w1c_zero", 3'd3, 32'h4);
        drain();
        wr(2'd3, 32'h1);
        push("w1c_clear_bit", 3'd3, 32'h4);
        drain();
        wr(2'd2, 32'h5);
        push("irq_bit2", SEL_IRQ, 32'h1);
        drain();
        wr(2'd3, 32'h4);
        push("w1c_bit2", 3'd3, 32'h0);
        push("irq_bit2_off", SEL_IRQ, 32'h0);
        drain();

        // Release keys: rising edges must not be captured.
        in_port = 4'hF;
        tick(LAT + 2);
        push("rise_data", 3'd0, 32'hF);
        push("rise_nocap", 3'd3, 32'h0);
        drain();

        // Writes to read-only / reserved addresses and upper write bits.
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        push("ro_data", 3'd0, 32'hF);
        push("rsvd_zero", 3'd1, 32'h0);
        push("mask_kept", 3'd2, 32'h5);
        drain();
        wr(2'd2, 32'hFFFF_FFF0);
        push("mask_hi_zero", 3'd2, 32'h0);
        drain();

`ifdef GAME_SOC_KEYS_DEBOUNCE_EN
        // Short glitch on bit 1 is filtered.
        in_port = 4'hD;
        tick(10);
        in_port = 4'hF;
        tick(D + 4);
        push("glitch_data", 3'd0, 32'hF);
        push("glitch_nocap", 3'd3, 32'h0);
        drain();
        // Long press on bit 1 passes after D cycles.
        in_port = 4'hD;
        tick(LAT - 1);
        push("hold_data_early", 3'd0, 32'hF);
        drain();
        tick(1);
        push("hold_data", 3'd0, 32'hD);
        drain();
        tick(1);
        push("hold_cap", 3'd3, 32'h2);
        drain();
        in_port = 4'hF;
        tick(LAT + 2);
        wr(2'd3, 32'h2);
        push("hold_clr", 3'd3, 32'h0);
        drain();
`endif

        // Reset in the middle of a pending change.
        wr(2'd2, 32'h4);
        in_port = 4'hB;
        tick(PRE_RST);
        reset = 1'b1;
        tick(1);
        in_port = 4'hF;
        tick(1);
        reset = 1'b0;
        push("mrst_data", 3'd0, 32'hF);
        push("mrst_cap", 3'd3, 32'h0);
        push("mrst_mask", 3'd2, 32'h0);
        drain();
        tick(LAT + 3);
        push("mrst_data_late", 3'd0, 32'hF);
        push("mrst_cap_late", 3'd3, 32'h0);
        push("mrst_irq", SEL_IRQ, 32'h0);
        drain();

        // Full latency again after reset.
        in_port = 4'hB;
        tick(LAT - 1);
        push("post_data_early", 3'd0, 32'hF);
        drain();
        tick(1);
        push("post_data", 3'd0, 32'hB);
        drain();
        tick(1);
        push("post_cap", 3'd3, 32'h4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_soc_keys_pio.md
GAME_SOC_KEYS_PIO -- requirements
Module: game_soc_keys_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input bits.
REQ-002 SHALL have parameter EDGE_SEL, default 1: capture edge type, 0=rising, 1=falling, 2=any.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive mismatch cycles before a debounced bit changes; range 2..65535.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  zero-wait-state read data.
REQ-012 in_port  input  WIDTH  asynchronous key inputs, active-low, idle high.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-015 Without debounce, stable SHALL load sync2 every cycle, so an in_port change is visible in stable after the 3rd rising edge.
REQ-016 stable_d SHALL register stable every cycle; edge per bit = rising (stable & ~stable_d), falling (~stable & stable_d), or any (stable ^ stable_d), per EDGE_SEL.
REQ-017 A detected edge SHALL set the matching edge_capture bit on the following rising edge and hold it until cleared.
REQ-018 Register map: addr 0 data = stable (RO); addr 1 reserved, reads 0; addr 2 irq_mask (RW); addr 3 edge_capture (write-1-to-clear).
REQ-019 A write SHALL occur when chipselect=1 and write_n=0; writes to addr 0 and addr 1 SHALL be ignored.
REQ-020 readdata SHALL be combinational from address, with bits above WIDTH-1 zero; chipselect SHALL NOT gate readdata.
REQ-021 irq SHALL equal OR-reduction of (edge_capture & irq_mask), combinational from registers.
REQ-022 A new edge and a W1C clear on the same bit in the same cycle SHALL leave the bit set (edge wins).
REQ-023 Clearing a bit whose edge_capture is 0 SHALL have no effect; writing 0 bits SHALL leave bits unchanged.

Reset
REQ-024 Reset SHALL set sync1, sync2, stable and stable_d to all ones.
REQ-025 Reset SHALL set irq_mask=0, edge_capture=0 and debounce counters=0, giving irq=0 and readdata at addr 0 = all ones.
REQ-026 Reset asserted mid-debounce or with pending edges SHALL discard them; no edge SHALL be reported for transitions that occur only across reset.

Configuration
REQ-027 Macro GAME_SOC_KEYS_DEBOUNCE_EN defined: each bit SHALL have a counter that clears when sync2==stable and otherwise increments.
REQ-028 When that counter is at DEBOUNCE_CYCLES-1 with a mismatch, stable SHALL load sync2 and the counter SHALL clear; a change therefore appears DEBOUNCE_CYCLES edges after sync2 changes.
REQ-029 Glitches shorter than DEBOUNCE_CYCLES SHALL NOT change stable or set edge_capture.
REQ-030 Macro undefined: no counters SHALL exist and REQ-015 timing SHALL apply.

Structure
REQ-031 Shared package game_soc_pio_pkg SHALL hold the register address constants (DATA=0, IRQ_MASK=2, EDGE_CAP=3) and the EDGE_SEL encodings.
REQ-032 Debounce SHALL be a sub-module game_soc_pio_debounce (WIDTH-wide vector, per-bit counters), instantiated only under GAME_SOC_KEYS_DEBOUNCE_EN.

Verification
REQ-033 Reset check: assert reset, release, read addr 0 -> 0xF; addr 2 and addr 3 -> 0; irq=0.
REQ-034 No debounce, falling edge: in_port 0xF->0xE -> addr 0 reads 0xE after edge 3; edge_capture=0x1 after edge 4; irq stays 0 (mask 0).
REQ-035 IRQ path: write addr 2=0x1 with edge_capture=0x1 -> irq=1; write addr 3=0x1 -> edge_capture=0, irq=0.
REQ-036 Simultaneous clear and edge on bit 2: W1C 0x4 in the same cycle the edge is detected -> edge_capture bit 2 remains 1.
REQ-037 Debounce on, D=16: bit 1 pulsed low for 10 cycles -> addr 0 stays 0xF, no capture; held low for 20 cycles -> addr 0=0xD, capture=0x2.
REQ-038 Reset mid-debounce: assert reset at cycle 8 of a 16-cycle mismatch -> after release stable=0xF, counter restarts, edge_capture=0.
